// File: rtl/prog_fetch.sv
// prog_fetch: streams a contiguous run of program-memory words into a
// small prefetch FIFO and presents them on a valid/ready stream.
module prog_fetch #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REM_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               infl_q, infl_d;
  logic               infl_last_q, infl_last_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic               fifo_last [FIFO_DEPTH];

  logic [CNT_W-1:0]   credit;
  logic               issue;
  logic               last_issue;
  logic               push;
  logic               pop;
  logic               head_last;
  logic               final_hs;
  logic               have_word;

  // Read credit: FIFO occupancy plus the read still in flight.
  always_comb begin
    credit     = cnt_q + CNT_W'(infl_q);
    issue      = (state_q == FETCH) &&
                 (credit < CNT_W'(FIFO_DEPTH));
    last_issue = issue && (rem_q == REM_W'(1));
  end

  // FIFO handshake terms and the end-of-run condition.
  always_comb begin
    have_word = (cnt_q != '0);
    push      = infl_q;
    pop       = have_word && out_ready;
    head_last = fifo_last[rd_ptr_q];
    final_hs  = pop && head_last;
  end

  // Run control: state, address and remaining-issue count.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = start_addr;
          if (len == '0) begin
            rem_d = {1'b1, {ADDR_W{1'b0}}};
          end else begin
            rem_d = {1'b0, len};
          end
        end
      end
      FETCH: begin
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (final_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - REM_W'(1);
    end
  end

  // In-flight tracking: data returns one cycle after each issue.
  always_comb begin
    infl_d      = issue;
    infl_last_d = last_issue;
  end

  // FIFO pointers and occupancy; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; reset abandons any run and drops in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  // FIFO storage; contents are only visible while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= mem_rdata;
      fifo_last[wr_ptr_q] <= infl_last_q;
    end
  end

  // Outputs; data and last are forced to zero when no word is held.
  always_comb begin
    mem_en    = issue;
    mem_addr  = addr_q;
    out_valid = have_word;
    out_data  = have_word ? fifo_data[rd_ptr_q] : '0;
    out_last  = have_word && head_last;
    busy      = (state_q != IDLE);
    done      = done_q;
  end

endmodule
